btn_event_decoder: RTL and testbench
====================================

// Module: btn_event_decoder
// PURPOSE
//  Consumer side of the debounced-button interface. Takes a clean, synchronous button level.
//  Classifies each press as short press, long press or held with auto-repeat.
//  Emits one-clock event strobes to the control FSM, for example for disparity/threshold
//  up/down stepping. Sits between the debouncer's stable level and the user-control logic.
// PARAMETERS
//  TICK_DIV   100_000  clk cycles per ms tick (100 MHz -> 1 kHz); >= 2
//  LONG_MS    1000     ms held before a press is classified long; >= 2
//  REPEAT_MS  200      ms between o_repeat strobes while long-held; >= 1
// PORTS
//  clk       in   1  system clock; the only clock
//  reset     in   1  synchronous, active-high reset
//  i_btn     in   1  debounced button level, synchronous to clk, 1 = pressed
//  o_short   out  1  1-clk strobe: released before LONG_MS elapsed
//  o_long    out  1  1-clk strobe: LONG_MS reached while still pressed
//  o_repeat  out  1  1-clk strobe every REPEAT_MS after o_long, while still pressed
//  o_held    out  1  level: FSM is in PRESSED or LONG_HELD
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high.
//  - Reset: all outputs 0, FSM = IDLE, ms counter = 0, tick divider = 0. Reset mid-press aborts with no strobe.
//  - Tick: internal divider counts 0..TICK_DIV-1 and asserts tick for 1 clk at TICK_DIV-1.
//    It is free-running after reset, so the first tick is at cycle TICK_DIV after reset release.
//  - All outputs are registered. A strobe is high in the clk after the edge that sampled the causing condition.
//  - FSM states:
//    IDLE
//      i_btn=1 -> PRESSED; ms_cnt <= 0.
//    PRESSED
//      i_btn=0 -> o_short=1, go to IDLE.
//      Otherwise, on tick, ms_cnt++.
//      On tick with ms_cnt == LONG_MS-1 -> o_long=1, go to LONG_HELD, rep_cnt <= 0.
//    LONG_HELD
//      i_btn=0 -> go to IDLE with no strobe.
//      Otherwise, on tick, rep_cnt++.
//      On tick with rep_cnt == REPEAT_MS-1 -> o_repeat=1, rep_cnt <= 0.
//  - o_held = 1 in PRESSED and LONG_HELD. It is 0 in the cycle o_short is high.
//  - Simultaneous events in PRESSED: release in the same cycle as the LONG_MS tick -> release wins; o_short only.
//  - Simultaneous events in LONG_HELD: release in the same cycle as the repeat tick -> no o_repeat.
//  - A press released before any tick still yields o_short. Input is pre-debounced; no minimum width is applied.
//  - Re-press in the cycle after release: IDLE then PRESSED. Back-to-back presses each yield their own strobe.
//  - At most one of o_short/o_long/o_repeat is high in any cycle.
//  - Widths: ms_cnt is $clog2(LONG_MS) bits, rep_cnt is $clog2(REPEAT_MS+1) bits, divider is $clog2(TICK_DIV) bits.
//    Counters never wrap while in use; comparisons use equality at the exact terminal value.
//  - Hold length is unbounded: LONG_HELD repeats forever at the REPEAT_MS period.
// STRUCTURE
//  - Shared package btn_pkg: FSM state encoding (IDLE=2'd0, PRESSED=2'd1, LONG_HELD=2'd2) and default timing constants.
//  - Sub-module ms_tick_gen (param TICK_DIV; ports clk, reset, o_tick) supplies the ms strobe.
//    It is reusable by other UI blocks.
//  - Rest: one state register, two counters, and registered output logic in this module.
// TESTING (bench parameters: TICK_DIV=4, LONG_MS=10, REPEAT_MS=3)
//  1 Short press: i_btn high 20 clk then low.
//    -> one o_short 1 clk after the low is sampled; o_long and o_repeat never high.
//  2 Long hold: i_btn high 100 clk.
//    -> o_long once, on the 10th tick after press.
//    -> o_repeat on every 3rd tick thereafter.
//    -> after release: no strobe, o_held drops.
//  3 Race: release exactly on the cycle of the 10th tick -> o_short=1, o_long stays 0.
//  4 Reset mid LONG_HELD: assert reset 1 clk.
//    -> all outputs 0 next clk; no strobe on the following release; FSM IDLE.
//  5 Glitch-free back-to-back: press 1 clk, low 1 clk, press 1 clk.
//    -> two separate o_short strobes; no overlap of strobes in any cycle.
//  6 Reset release: i_btn held high through reset.
//    -> PRESSED entered on the first clk after reset drops; o_long at the 10th tick.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and default timing for the button event decoder and its tick source.
// Pure declarations; no logic, no latency.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_LONG_HELD = 2'd2
  } btn_state_e;

  localparam int DEF_TICK_DIV  = 100_000;
  localparam int DEF_LONG_MS   = 1000;
  localparam int DEF_REPEAT_MS = 200;

  function automatic logic is_held(input btn_state_e s);
    return (s == ST_PRESSED) || (s == ST_LONG_HELD);
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running divider: one-clk o_tick every TICK_DIV clks, first at cycle TICK_DIV after reset.
// Tick is a decode of the counter register; no backpressure, never stalls.
module ms_tick_gen
  import btn_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic o_tick
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  always_comb begin
    div_d = div_q + 1'b1;
    if (div_q == DIV_LAST) begin
      div_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign o_tick = (div_q == DIV_LAST);

endmodule

// File: rtl/btn_event_decoder.sv
// Classifies debounced presses into short / long / auto-repeat strobes; all outputs registered,
// strobes appear one clk after the sampling edge. No backpressure: strobes are fire-and-forget.
module btn_event_decoder
  import btn_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int LONG_MS   = DEF_LONG_MS,
  parameter int REPEAT_MS = DEF_REPEAT_MS
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_short,
  output logic o_long,
  output logic o_repeat,
  output logic o_held
);

  localparam int MS_W = $clog2(LONG_MS);
  localparam int RP_W = $clog2(REPEAT_MS + 1);
  localparam logic [MS_W-1:0] MS_LAST = MS_W'(LONG_MS - 1);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_MS - 1);

  btn_state_e      state_q, state_d;
  logic [MS_W-1:0] ms_cnt_q, ms_cnt_d;
  logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic            short_q, short_d;
  logic            long_q, long_d;
  logic            rep_stb_q, rep_stb_d;
  logic            held_q, held_d;
  logic            tick;

  ms_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .o_tick(tick)
  );

  // Release is tested before the tick so a release on the terminal tick wins.
  always_comb begin
    state_d   = state_q;
    ms_cnt_d  = ms_cnt_q;
    rep_cnt_d = rep_cnt_q;
    short_d   = 1'b0;
    long_d    = 1'b0;
    rep_stb_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_btn) begin
          state_d  = ST_PRESSED;
          ms_cnt_d = '0;
        end
      end
      ST_PRESSED: begin
        if (!i_btn) begin
          short_d = 1'b1;
          state_d = ST_IDLE;
        end else if (tick) begin
          if (ms_cnt_q == MS_LAST) begin
            long_d    = 1'b1;
            state_d   = ST_LONG_HELD;
            rep_cnt_d = '0;
          end else begin
            ms_cnt_d = ms_cnt_q + 1'b1;
          end
        end
      end
      ST_LONG_HELD: begin
        if (!i_btn) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (rep_cnt_q == RP_LAST) begin
            rep_stb_d = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    held_d = is_held(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ms_cnt_q  <= '0;
      rep_cnt_q <= '0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      rep_stb_q <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ms_cnt_q  <= ms_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      short_q   <= short_d;
      long_q    <= long_d;
      rep_stb_q <= rep_stb_d;
      held_q    <= held_d;
    end
  end

  assign o_short  = short_q;
  assign o_long   = long_q;
  assign o_repeat = rep_stb_q;
  assign o_held   = held_q;

endmodule

// File: tb/tb_btn_event_decoder.sv
// Scenario bench for btn_event_decoder: expected strobes (kind, cycle) are queued at stimulus time
// and matched by a negedge monitor whenever the DUT emits a strobe.
module tb_btn_event_decoder;

  localparam int TICK_DIV  = 4;
  localparam int LONG_MS   = 10;
  localparam int REPEAT_MS = 3;
  localparam int K_SHORT   = 0;
  localparam int K_LONG    = 1;
  localparam int K_REP     = 2;

  logic clk = 1'b0;
  logic reset;
  logic i_btn;
  logic o_short, o_long, o_repeat, o_held;

  int cyc      = 0;
  int rst_edge = 0;
  int n_checks = 0;
  int n_pass   = 0;
  int exp_kind[$];
  int exp_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  btn_event_decoder #(
    .TICK_DIV (TICK_DIV),
    .LONG_MS  (LONG_MS),
    .REPEAT_MS(REPEAT_MS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (i_btn),
    .o_short (o_short),
    .o_long  (o_long),
    .o_repeat(o_repeat),
    .o_held  (o_held)
  );

  // First edge after e that samples a tick; ticks are sampled every TICK_DIV edges after reset.
  function automatic int next_tick(input int e);
    int f;
    f = e + 1;
    while (((f - rst_edge) % TICK_DIV) != 0) f++;
    return f;
  endfunction

  // Button seen at edge c0+1; release (or reset) sampled at edge c_end+1.
  task automatic expect_press(input int c0, input int c_end, input bit by_reset);
    int f, k;
    bit is_long;
    k = 0;
    is_long = 1'b0;
    f = next_tick(c0 + 1);
    while (f < c_end + 1) begin
      k++;
      if (k == LONG_MS) begin
        exp_kind.push_back(K_LONG);
        exp_cyc.push_back(f);
        is_long = 1'b1;
      end else if (is_long && ((k - LONG_MS) % REPEAT_MS) == 0) begin
        exp_kind.push_back(K_REP);
        exp_cyc.push_back(f);
      end
      f += TICK_DIV;
    end
    if (!is_long && !by_reset) begin
      exp_kind.push_back(K_SHORT);
      exp_cyc.push_back(c_end + 1);
    end
  endtask

  always @(negedge clk) begin
    int kind, ek, ec;
    if ((o_short === 1'b1) || (o_long === 1'b1) || (o_repeat === 1'b1)) begin
      n_checks++;
      if ($countones({o_short, o_long, o_repeat}) != 1)
        $display("FAIL strobe_overlap cyc=%0d got s/l/r=%b%b%b want exactly one", cyc, o_short, o_long, o_repeat);
      else
        n_pass++;
      kind = (o_short === 1'b1) ? K_SHORT : (o_long === 1'b1) ? K_LONG : K_REP;
      n_checks++;
      if (exp_kind.size() == 0) begin
        $display("FAIL unexpected_strobe cyc=%0d got kind=%0d want none", cyc, kind);
      end else begin
        ek = exp_kind.pop_front();
        ec = exp_cyc.pop_front();
        if (kind !== ek || cyc !== ec)
          $display("FAIL strobe_match got kind=%0d cyc=%0d want kind=%0d cyc=%0d", kind, cyc, ek, ec);
        else
          n_pass++;
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    i_btn = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({o_short, o_long, o_repeat, o_held} !== 4'b0000)
      $display("FAIL reset_outputs got %b want 0000", {o_short, o_long, o_repeat, o_held});
    else
      n_pass++;
    reset = 1'b0;
    rst_edge = cyc;
    repeat (8) @(negedge clk);
    n_checks++;
    if (o_held !== 1'b0) $display("FAIL idle_held got %b want 0", o_held);
    else n_pass++;
  endtask

  task automatic test_short();
    int c0;
    @(negedge clk);
    c0 = cyc;
    expect_press(c0, c0 + 20, 1'b0);
    i_btn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (o_held !== 1'b1) $display("FAIL short_held_on got %b want 1", o_held);
    else n_pass++;
    repeat (19) @(negedge clk);
    i_btn = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({o_short, o_held} !== 2'b10) $display("FAIL short_strobe got short/held=%b want 10", {o_short, o_held});
    else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++;
    if (exp_kind.size() != 0) begin
      $display("FAIL short_missing got %0d pending want 0", exp_kind.size());
      exp_kind.delete(); exp_cyc.delete();
    end else n_pass++;
  endtask

  task automatic test_long_hold();
    int c0;
    @(negedge clk);
    c0 = cyc;
    expect_press(c0, c0 + 100, 1'b0);
    i_btn = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (cyc == c0 + 70) begin
        n_checks++;
        if (o_held !== 1'b1) $display("FAIL long_held_on got %b want 1", o_held);
        else n_pass++;
      end
    end
    i_btn = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_held !== 1'b0) $display("FAIL long_held_drop got %b want 0", o_held);
    else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++;
    if (exp_kind.size() != 0) begin
      $display("FAIL long_missing got %0d pending want 0", exp_kind.size());
      exp_kind.delete(); exp_cyc.delete();
    end else n_pass++;
  endtask

  task automatic test_race();
    int c0, f10, len;
    @(negedge clk);
    c0 = cyc;
    f10 = next_tick(c0 + 1) + (LONG_MS - 1) * TICK_DIV;
    len = f10 - 1 - c0;
    expect_press(c0, c0 + len, 1'b0);
    i_btn = 1'b1;
    repeat (len) @(negedge clk);
    i_btn = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({o_short, o_long} !== 2'b10) $display("FAIL race_strobe cyc=%0d got short/long=%b want 10", cyc, {o_short, o_long});
    else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++;
    if (exp_kind.size() != 0) begin
      $display("FAIL race_missing got %0d pending want 0", exp_kind.size());
      exp_kind.delete(); exp_cyc.delete();
    end else n_pass++;
  endtask

  task automatic test_reset_mid_hold();
    int c0;
    @(negedge clk);
    c0 = cyc;
    expect_press(c0, c0 + 60, 1'b1);
    i_btn = 1'b1;
    repeat (60) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({o_short, o_long, o_repeat, o_held} !== 4'b0000)
      $display("FAIL midreset_outputs got %b want 0000", {o_short, o_long, o_repeat, o_held});
    else n_pass++;
    reset = 1'b0;
    i_btn = 1'b0;
    rst_edge = cyc;
    repeat (12) @(negedge clk);
    n_checks++;
    if (o_held !== 1'b0) $display("FAIL midreset_idle got held=%b want 0", o_held);
    else n_pass++;
    n_checks++;
    if (exp_kind.size() != 0) begin
      $display("FAIL midreset_missing got %0d pending want 0", exp_kind.size());
      exp_kind.delete(); exp_cyc.delete();
    end else n_pass++;
  endtask

  task automatic test_back_to_back();
    int c0;
    @(negedge clk);
    c0 = cyc;
    expect_press(c0, c0 + 1, 1'b0);
    expect_press(c0 + 2, c0 + 3, 1'b0);
    i_btn = 1'b1;
    @(negedge clk); i_btn = 1'b0;
    @(negedge clk); i_btn = 1'b1;
    @(negedge clk); i_btn = 1'b0;
    n_checks++;
    if (o_short !== 1'b0) $display("FAIL b2b_gap got short=%b want 0", o_short);
    else n_pass++;
    repeat (6) @(negedge clk);
    n_checks++;
    if (exp_kind.size() != 0) begin
      $display("FAIL b2b_missing got %0d pending want 0", exp_kind.size());
      exp_kind.delete(); exp_cyc.delete();
    end else n_pass++;
  endtask

  task automatic test_reset_release_pressed();
    int c0;
    reset = 1'b1;
    i_btn = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (o_held !== 1'b0) $display("FAIL rr_in_reset got held=%b want 0", o_held);
    else n_pass++;
    reset = 1'b0;
    rst_edge = cyc;
    c0 = cyc;
    expect_press(c0, c0 + 60, 1'b0);
    @(negedge clk);
    n_checks++;
    if (o_held !== 1'b1) $display("FAIL rr_pressed got held=%b want 1", o_held);
    else n_pass++;
    while (cyc < c0 + 60) begin
      @(negedge clk);
      if (cyc == rst_edge + LONG_MS * TICK_DIV) begin
        n_checks++;
        if (o_long !== 1'b1) $display("FAIL rr_long cyc=%0d got %b want 1", cyc, o_long);
        else n_pass++;
      end
    end
    i_btn = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (exp_kind.size() != 0) begin
      $display("FAIL rr_missing got %0d pending want 0", exp_kind.size());
      exp_kind.delete(); exp_cyc.delete();
    end else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_short();
    test_long_hold();
    test_race();
    test_reset_mid_hold();
    test_back_to_back();
    test_reset_release_pressed();
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
